// File: rtl/i2c_target_regif_if.sv
// I2C pin bundle for the register-interface target: pad inputs plus
// drive value/enable pairs for SCL and SDA.
interface i2c_target_regif_if;
    logic i2c_scl_i;
    logic i2c_scl_o;
    logic i2c_scl_e;
    logic i2c_sda_i;
    logic i2c_sda_o;
    logic i2c_sda_e;

    modport master (
        output i2c_scl_i, i2c_sda_i,
        input  i2c_scl_o, i2c_scl_e, i2c_sda_o, i2c_sda_e
    );

    modport slave (
        input  i2c_scl_i, i2c_sda_i,
        output i2c_scl_o, i2c_scl_e, i2c_sda_o, i2c_sda_e
    );
endinterface

// File: rtl/i2c_target_regif.sv
// I2C target: 7-bit address match, 8-bit register pointer, byte-wide
// register write/read port with pointer auto-increment.
module i2c_target_regif #(
    parameter logic [6:0]  DEV_ADDR    = 7'h50,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYC    = 2
) (
    input  logic              clk,
    input  logic              reset,
    i2c_target_regif_if.slave i2c,
    output logic [7:0]        reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);
    localparam int unsigned HW = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d, scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]             bit_cnt, bit_cnt_n;
    logic [7:0]             shift, shift_n, rx_byte, reg_addr_n, reg_wdata_n;
    logic                   rw, rw_n, sda_e, sda_e_n, sda_pend, sda_pend_n, drv;
    logic                   reg_wr_n, reg_rd_n, busy_n;
    logic [HW-1:0]          hold_cnt, hold_cnt_n;

    assign i2c.i2c_scl_o = 1'b0;
    assign i2c.i2c_scl_e = 1'b0;
    assign i2c.i2c_sda_o = 1'b0;
    assign i2c.i2c_sda_e = sda_e;

    // Synchronizers and history flops reset to 1 so reset looks like an idle bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c.i2c_scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c.i2c_sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign rx_byte   = {shift[6:0], sda_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            rw        <= 1'b0;
            sda_e     <= 1'b0;
            sda_pend  <= 1'b0;
            hold_cnt  <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            rw        <= rw_n;
            sda_e     <= sda_e_n;
            sda_pend  <= sda_pend_n;
            hold_cnt  <= hold_cnt_n;
            reg_addr  <= reg_addr_n;
            reg_wdata <= reg_wdata_n;
            reg_wr    <= reg_wr_n;
            reg_rd    <= reg_rd_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        rw_n        = rw;
        sda_e_n     = sda_e;
        sda_pend_n  = sda_pend;
        hold_cnt_n  = hold_cnt;
        reg_addr_n  = reg_addr;
        reg_wdata_n = reg_wdata;
        reg_wr_n    = 1'b0;
        reg_rd_n    = 1'b0;
        busy_n      = busy;
        drv         = 1'b0;

        if (reg_rd) shift_n = reg_rdata;
        if (reg_wr) reg_addr_n = reg_addr + 8'd1;

        // SDA changes are deferred HOLD_CYC clocks past the observed SCL fall.
        if (hold_cnt != '0) begin
            hold_cnt_n = hold_cnt - 1'b1;
            if (hold_cnt == HW'(1)) sda_e_n = sda_pend;
        end

        if (start_det) begin
            state_n    = ADDR;
            bit_cnt_n  = '0;
            shift_n    = '0;
            sda_e_n    = 1'b0;
            hold_cnt_n = '0;
            if (state == IDLE) busy_n = 1'b0;
        end else if (stop_det) begin
            state_n    = IDLE;
            sda_e_n    = 1'b0;
            hold_cnt_n = '0;
            busy_n     = 1'b0;
        end else if (scl_rise) begin
            case (state)
                ADDR, PTR, WDATA: begin
                    shift_n   = rx_byte;
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_n = '0;
                        if (state == ADDR) begin
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                state_n = ADDR_ACK;
                                busy_n  = 1'b1;
                                rw_n    = rx_byte[0];
                            end else begin
                                state_n = IDLE;
                            end
                        end else if (state == PTR) begin
                            reg_addr_n = rx_byte;
                            state_n    = PTR_ACK;
                        end else begin
                            reg_wr_n    = 1'b1;
                            reg_wdata_n = rx_byte;
                            state_n     = WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    bit_cnt_n = '0;
                    if (rw) begin
                        reg_rd_n = 1'b1;
                        state_n  = RDATA;
                    end else begin
                        state_n  = PTR;
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    bit_cnt_n = '0;
                    state_n   = WDATA;
                end
                RDATA: bit_cnt_n = bit_cnt + 4'd1;
                RDATA_ACK: begin
                    bit_cnt_n = '0;
                    if (!sda_s) begin
                        reg_rd_n = 1'b1;
                        state_n  = RDATA;
                    end else begin
                        state_n  = IDLE;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state)
                ADDR_ACK, PTR_ACK, WDATA_ACK: drv = 1'b1;
                RDATA: begin
                    if (bit_cnt == 4'd8) begin
                        state_n    = RDATA_ACK;
                        reg_addr_n = reg_addr + 8'd1;
                    end else begin
                        drv     = ~shift[7];
                        shift_n = {shift[6:0], 1'b0};
                    end
                end
                default: drv = 1'b0;
            endcase
            if (HOLD_CYC == 0) begin
                sda_e_n = drv;
            end else begin
                sda_pend_n = drv;
                hold_cnt_n = HW'(HOLD_CYC);
            end
        end
    end
endmodule
